// File: rtl/vga_pkg.sv
// Shared VGA drawing definitions: filler FSM states and default screen geometry.
package vga_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_COLOR_DEPTH = 3;
    localparam int DEF_NX          = 8;
    localparam int DEF_NY          = 7;
    localparam int DEF_MN          = 15;
    localparam int DEF_COLS        = 160;
    localparam int DEF_ROWS        = 120;

endpackage

// File: rtl/vga_rect_filler_if.sv
// Command and video-memory write bundle of the rectangle filler.
// master = command source / memory side, slave = the filler; req_outline only with VGA_RECT_OUTLINE_EN.
interface vga_rect_filler_if import vga_pkg::*; #(
    parameter int COLOR_DEPTH = DEF_COLOR_DEPTH,
    parameter int nX          = DEF_NX,
    parameter int nY          = DEF_NY,
    parameter int Mn          = DEF_MN
);
    logic                   req_valid;
    logic                   req_ready;
    logic [nX-1:0]          req_x0;
    logic [nY-1:0]          req_y0;
    logic [nX-1:0]          req_w;
    logic [nY-1:0]          req_h;
    logic [COLOR_DEPTH-1:0] req_color;
`ifdef VGA_RECT_OUTLINE_EN
    logic                   req_outline;
`endif
    logic                   plot_valid;
    logic                   plot_ready;
    logic [nX-1:0]          plot_x;
    logic [nY-1:0]          plot_y;
    logic [Mn-1:0]          plot_addr;
    logic [COLOR_DEPTH-1:0] plot_color;
    logic                   busy;
    logic                   done;

    modport master (
`ifdef VGA_RECT_OUTLINE_EN
        output req_outline,
`endif
        output req_valid, req_x0, req_y0, req_w, req_h, req_color, plot_ready,
        input  req_ready, plot_valid, plot_x, plot_y, plot_addr, plot_color, busy, done
    );

    modport slave (
`ifdef VGA_RECT_OUTLINE_EN
        input  req_outline,
`endif
        input  req_valid, req_x0, req_y0, req_w, req_h, req_color, plot_ready,
        output req_ready, plot_valid, plot_x, plot_y, plot_addr, plot_color, busy, done
    );

endinterface

// File: rtl/vga_address_translator.sv
// Maps screen (x, y) to linear video-memory address y*COLS + x. Purely combinational.
module vga_address_translator import vga_pkg::*; #(
    parameter int nX   = DEF_NX,
    parameter int nY   = DEF_NY,
    parameter int Mn   = DEF_MN,
    parameter int COLS = DEF_COLS
) (
    input  logic [nX-1:0] x,
    input  logic [nY-1:0] y,
    output logic [Mn-1:0] mem_address
);

    assign mem_address = Mn'(int'(y) * COLS + int'(x));

endmodule

// File: rtl/vga_rect_filler.sv
// Rectangle fill engine: one raster-order, screen-clipped memory write per covered pixel (outline mode: VGA_RECT_OUTLINE_EN).
// Latency: first write is valid the cycle after accept; 1 pixel/cycle, w*h FILL cycles + 1 DONE cycle unstalled.
// Backpressure: plot_* held while plot_valid && !plot_ready; clipped pixels never wait; req_ready only in IDLE.
module vga_rect_filler import vga_pkg::*; #(
    parameter int COLOR_DEPTH = DEF_COLOR_DEPTH,
    parameter int nX          = DEF_NX,
    parameter int nY          = DEF_NY,
    parameter int Mn          = DEF_MN,
    parameter int COLS        = DEF_COLS,
    parameter int ROWS        = DEF_ROWS
) (
    input  logic              vga_clock,
    input  logic              resetn,
    vga_rect_filler_if.slave  bus
);

    state_t                 state;
    logic [nX-1:0]          x0_q, w_q, cx;
    logic [nY-1:0]          y0_q, h_q, cy;
`ifdef VGA_RECT_OUTLINE_EN
    logic                   outline_q;
`endif
    logic                   plot_valid_q;
    logic [nX-1:0]          plot_x_q;
    logic [nY-1:0]          plot_y_q;
    logic [COLOR_DEPTH-1:0] plot_color_q;

    logic                   stall;
    logic                   last_px;
    logic [nX-1:0]          adv_cx;
    logic [nY-1:0]          adv_cy;

    // Target pixel: the first pixel of an incoming command in IDLE, else the next pixel in raster order.
    logic [nX-1:0]          t_x0, t_w, t_cx;
    logic [nY-1:0]          t_y0, t_h, t_cy;
    logic                   t_outline;
    logic [nX:0]            t_x;
    logic [nY:0]            t_y;
    logic                   t_perimeter;
    logic                   t_plot;

    assign stall = plot_valid_q && !bus.plot_ready;

    always_comb begin
        last_px     = 1'b0;
        adv_cx      = '0;
        adv_cy      = '0;
        t_x0        = '0;
        t_y0        = '0;
        t_w         = '0;
        t_h         = '0;
        t_cx        = '0;
        t_cy        = '0;
        t_outline   = 1'b0;
        t_x         = '0;
        t_y         = '0;
        t_perimeter = 1'b0;
        t_plot      = 1'b0;

        last_px = (cx == w_q - nX'(1)) && (cy == h_q - nY'(1));
        if (cx == w_q - nX'(1)) begin
            adv_cx = '0;
            adv_cy = cy + nY'(1);
        end else begin
            adv_cx = cx + nX'(1);
            adv_cy = cy;
        end

        if (state == IDLE) begin
            t_x0 = bus.req_x0;
            t_y0 = bus.req_y0;
            t_w  = bus.req_w;
            t_h  = bus.req_h;
            t_cx = '0;
            t_cy = '0;
`ifdef VGA_RECT_OUTLINE_EN
            t_outline = bus.req_outline;
`endif
        end else begin
            t_x0 = x0_q;
            t_y0 = y0_q;
            t_w  = w_q;
            t_h  = h_q;
            t_cx = adv_cx;
            t_cy = adv_cy;
`ifdef VGA_RECT_OUTLINE_EN
            t_outline = outline_q;
`endif
        end

        // One bit wider so pixels past the coordinate range clip instead of wrapping onto the screen.
        t_x         = {1'b0, t_x0} + {1'b0, t_cx};
        t_y         = {1'b0, t_y0} + {1'b0, t_cy};
        t_perimeter = (t_cx == '0) || (t_cx == t_w - nX'(1)) ||
                      (t_cy == '0) || (t_cy == t_h - nY'(1));
        t_plot      = (t_x < (nX+1)'(COLS)) && (t_y < (nY+1)'(ROWS)) &&
                      (!t_outline || t_perimeter);
    end

    always_ff @(posedge vga_clock) begin
        if (!resetn) begin
            state        <= IDLE;
            x0_q         <= '0;
            y0_q         <= '0;
            w_q          <= '0;
            h_q          <= '0;
            cx           <= '0;
            cy           <= '0;
`ifdef VGA_RECT_OUTLINE_EN
            outline_q    <= 1'b0;
`endif
            plot_valid_q <= 1'b0;
            plot_x_q     <= '0;
            plot_y_q     <= '0;
            plot_color_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        x0_q         <= bus.req_x0;
                        y0_q         <= bus.req_y0;
                        w_q          <= bus.req_w;
                        h_q          <= bus.req_h;
`ifdef VGA_RECT_OUTLINE_EN
                        outline_q    <= bus.req_outline;
`endif
                        plot_color_q <= bus.req_color;
                        cx           <= '0;
                        cy           <= '0;
                        if (bus.req_w == '0 || bus.req_h == '0) begin
                            state <= DONE;
                        end else begin
                            state        <= FILL;
                            plot_valid_q <= t_plot;
                            plot_x_q     <= t_x[nX-1:0];
                            plot_y_q     <= t_y[nY-1:0];
                        end
                    end
                end
                FILL: begin
                    if (!stall) begin
                        if (last_px) begin
                            state        <= DONE;
                            plot_valid_q <= 1'b0;
                        end else begin
                            cx           <= adv_cx;
                            cy           <= adv_cy;
                            plot_valid_q <= t_plot;
                            plot_x_q     <= t_x[nX-1:0];
                            plot_y_q     <= t_y[nY-1:0];
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state        <= IDLE;
                    plot_valid_q <= 1'b0;
                end
            endcase
        end
    end

    vga_address_translator #(
        .nX   (nX),
        .nY   (nY),
        .Mn   (Mn),
        .COLS (COLS)
    ) u_addr (
        .x           (plot_x_q),
        .y           (plot_y_q),
        .mem_address (bus.plot_addr)
    );

    assign bus.plot_valid = plot_valid_q;
    assign bus.plot_x     = plot_x_q;
    assign bus.plot_y     = plot_y_q;
    assign bus.plot_color = plot_color_q;
    assign bus.req_ready  = (state == IDLE);
    assign bus.busy       = (state != IDLE);
    assign bus.done       = (state == DONE);

endmodule

// File: tb/tb_vga_rect_filler.sv
// Bench for vga_rect_filler: directed vector table, reset-abort sequence, and randomized
// commands checked against a pixel-list model built from nested row/column loops.
module tb_vga_rect_filler;

    localparam int COLS = 160;
    localparam int ROWS = 120;

    logic vga_clock = 1'b0;
    logic resetn    = 1'b0;

    always #5 vga_clock = ~vga_clock;

    vga_rect_filler_if bus ();

    vga_rect_filler dut (
        .vga_clock (vga_clock),
        .resetn    (resetn),
        .bus       (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive_req(input int x0, y0, w, h, color, input bit ol);
        bus.req_x0    = 8'(x0);
        bus.req_y0    = 7'(y0);
        bus.req_w     = 8'(w);
        bus.req_h     = 7'(h);
        bus.req_color = 3'(color);
`ifdef VGA_RECT_OUTLINE_EN
        bus.req_outline = ol;
`else
        if (ol) $display("note: outline requested in a build without outline support");
`endif
    endtask

    // Issues one command from a negedge with the DUT idle; returns to a negedge with the DUT idle.
    // mode 0: plot_ready always 1, 1: ready on even cycles only, 2: random ready.
    task automatic run_cmd(input int x0, y0, w, h, color, input bit ol, input int mode,
                           output int n_wr, output int done_cyc, output int first_addr);
        int  exp_xyc[$];
        int  exp_addr[$];
        int  n_exp;
        int  stalls;
        bit  prev_stall;
        int  hx, hy, ha, hc;
        bit  rdy;

        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                int X, Y;
                bit perim;
                X     = x0 + c;
                Y     = y0 + r;
                perim = (c == 0) || (c == w - 1) || (r == 0) || (r == h - 1);
                if (X < COLS && Y < ROWS && (!ol || perim)) begin
                    exp_xyc.push_back(X | (Y << 8) | (color << 16));
                    exp_addr.push_back(Y * COLS + X);
                end
            end
        end
        n_exp = exp_xyc.size();

        drive_req(x0, y0, w, h, color, ol);
        bus.req_valid = 1'b1;
        n_wr = 0; done_cyc = 0; first_addr = -1; stalls = 0; prev_stall = 1'b0;
        hx = 0; hy = 0; ha = 0; hc = 0;

        for (int k = 1; k <= 3000; k++) begin
            @(negedge vga_clock);
            // Garbage on the request side while busy must be ignored.
            drive_req(int'($urandom), int'($urandom), int'($urandom), int'($urandom),
                      int'($urandom), 1'($urandom));
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (k % 2 == 0);
                default: rdy = ($urandom_range(0, 3) != 0);
            endcase
            bus.plot_ready = rdy;
            if (k == 1) begin
                chk("busy_after_accept", int'(bus.busy), 1);
                chk("req_ready_low_busy", int'(bus.req_ready), 0);
            end
            if (prev_stall)
                chk("stall_hold", int'(bus.plot_valid && bus.plot_x == 8'(hx) &&
                    bus.plot_y == 7'(hy) && bus.plot_addr == 15'(ha) &&
                    bus.plot_color == 3'(hc)), 1);
            prev_stall = 1'b0;
            if (bus.done) begin
                done_cyc = k;
                bus.req_valid = 1'b0;
                break;
            end
            if (bus.plot_valid && bus.plot_ready) begin
                int got;
                got = int'(bus.plot_x) | (int'(bus.plot_y) << 8) | (int'(bus.plot_color) << 16);
                if (n_wr == 0) first_addr = int'(bus.plot_addr);
                n_wr++;
                if (exp_xyc.size() == 0) begin
                    chk("extra_write", got, -1);
                end else begin
                    chk("write_xyc", got, exp_xyc.pop_front());
                    chk("write_addr", int'(bus.plot_addr), exp_addr.pop_front());
                end
            end else if (bus.plot_valid) begin
                prev_stall = 1'b1;
                stalls++;
                hx = int'(bus.plot_x); hy = int'(bus.plot_y);
                ha = int'(bus.plot_addr); hc = int'(bus.plot_color);
            end
        end
        bus.req_valid = 1'b0;
        if (done_cyc == 0) chk("done_timeout", 0, 1);
        chk("write_count", n_wr, n_exp);
        chk("done_cycle", done_cyc, (w == 0 || h == 0) ? 1 : w * h + stalls + 1);

        @(negedge vga_clock);
        bus.plot_ready = 1'b1;
        chk("done_one_cycle", int'(bus.done), 0);
        chk("req_ready_after_done", int'(bus.req_ready), 1);
    endtask

    typedef struct {
        int x0, y0, w, h, color;
        bit ol;
        int mode;
        int exp_wr, exp_done, exp_addr;
    } vec_t;

    initial begin
        vec_t vecs[$];
        int   n_wr, done_cyc, first_addr;

        // {x0, y0, w, h, color, outline, ready mode, writes, done cycle, first addr}
        vecs.push_back('{10,  5,   3, 2, 5, 1'b0, 0, 6, 7,  810});   // 6 FILL + 1 DONE
        vecs.push_back('{10,  5,   3, 2, 5, 1'b0, 1, 6, 13, 810});   // each pixel stalls once
        vecs.push_back('{158, 119, 4, 2, 2, 1'b0, 0, 2, 9,  19198});
        vecs.push_back('{10,  10,  0, 7, 1, 1'b0, 0, 0, 1,  -1});
        vecs.push_back('{3,   4,   5, 0, 1, 1'b0, 0, 0, 1,  -1});
        vecs.push_back('{200, 10,  2, 2, 7, 1'b0, 0, 0, 5,  -1});
        vecs.push_back('{159, 119, 1, 1, 6, 1'b0, 0, 1, 2,  19199});
        vecs.push_back('{255, 0,   3, 1, 4, 1'b0, 0, 0, 4,  -1});    // no wrap to x=0
        vecs.push_back('{0,   127, 2, 1, 3, 1'b0, 0, 0, 3,  -1});
`ifdef VGA_RECT_OUTLINE_EN
        vecs.push_back('{0,   0,   3, 3, 5, 1'b1, 0, 8, 10, 0});
`endif

        bus.req_valid  = 1'b0;
        bus.plot_ready = 1'b1;
        drive_req(0, 0, 0, 0, 0, 1'b0);
        resetn = 1'b0;
        repeat (3) @(negedge vga_clock);
        chk("rst_plot_valid", int'(bus.plot_valid), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_req_ready", int'(bus.req_ready), 1);
        chk("rst_plot_xy", int'(bus.plot_x) + int'(bus.plot_y), 0);
        chk("rst_plot_addr", int'(bus.plot_addr), 0);
        chk("rst_plot_color", int'(bus.plot_color), 0);
        resetn = 1'b1;
        @(negedge vga_clock);

        foreach (vecs[i]) begin
            run_cmd(vecs[i].x0, vecs[i].y0, vecs[i].w, vecs[i].h, vecs[i].color,
                    vecs[i].ol, vecs[i].mode, n_wr, done_cyc, first_addr);
            chk($sformatf("vec%0d_writes", i), n_wr, vecs[i].exp_wr);
            chk($sformatf("vec%0d_done", i), done_cyc, vecs[i].exp_done);
            chk($sformatf("vec%0d_first_addr", i), first_addr, vecs[i].exp_addr);
        end

        // Reset in the middle of a 20x20 fill: immediate abort, no done pulse.
        drive_req(0, 0, 20, 20, 2, 1'b0);
        bus.req_valid = 1'b1;
        @(negedge vga_clock);
        bus.req_valid = 1'b0;
        repeat (5) @(negedge vga_clock);
        chk("midfill_busy", int'(bus.busy), 1);
        resetn = 1'b0;
        @(negedge vga_clock);
        chk("abort_plot_valid", int'(bus.plot_valid), 0);
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_done", int'(bus.done), 0);
        chk("abort_plot_addr", int'(bus.plot_addr), 0);
        @(negedge vga_clock);
        resetn = 1'b1;
        chk("abort_done_later", int'(bus.done), 0);
        chk("abort_req_ready", int'(bus.req_ready), 1);
        run_cmd(0, 0, 1, 1, 6, 1'b0, 0, n_wr, done_cyc, first_addr);
        chk("post_abort_writes", n_wr, 1);
        chk("post_abort_addr", first_addr, 0);

        // Randomized commands biased toward the right/bottom screen edges.
        for (int i = 0; i < 40; i++) begin
            int x0, y0, w, h;
            bit ol;
            x0 = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(150, 165);
            y0 = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 127) : $urandom_range(112, 124);
            w  = $urandom_range(0, 12);
            h  = $urandom_range(0, 5);
`ifdef VGA_RECT_OUTLINE_EN
            ol = 1'($urandom_range(0, 1));
`else
            ol = 1'b0;
`endif
            run_cmd(x0, y0, w, h, $urandom_range(0, 7), ol, 2, n_wr, done_cyc, first_addr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
